// File: rtl/count_monitor_pkg.sv
// Shared types and constants for count_monitor: FSM states, step classes
// and the step classifier used by the tracking FSM.
package count_monitor_pkg;

   localparam int         WRAP_W_DEF = 8;
   localparam logic [3:0] CNT_MAX    = 4'd15;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      TRACK = 2'd1,
      ERROR = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      STEP_HOLD    = 3'd0,
      STEP_INC     = 3'd1,
      STEP_WRAP    = 3'd2,
      STEP_RESTART = 3'd3,
      STEP_BAD     = 3'd4
   } step_t;

   // Wrap and restart are tested before the +1 rule because 15->0 is also a +1 step mod 16.
   function automatic step_t classify_step(input logic [3:0] prev, input logic [3:0] cur);
      logic [3:0] delta;
      delta = cur - prev;
      if ((prev == CNT_MAX) && (cur == 4'd0)) begin
         return STEP_WRAP;
      end else if ((cur == 4'd0) && (prev != 4'd0)) begin
         return STEP_RESTART;
      end else if (delta == 4'd0) begin
         return STEP_HOLD;
      end else if (delta == 4'd1) begin
         return STEP_INC;
      end else begin
         return STEP_BAD;
      end
   endfunction

endpackage

// File: rtl/cm_sync2.sv
// Two-flop synchronizer bringing the upstream count into the clk domain;
// both stages clear on the synchronous reset.
module cm_sync2 #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   // Two-stage capture chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= {W{1'b0}};
         r_sync <= {W{1'b0}};
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

// File: rtl/count_monitor.sv
// Monitors a free-running 4-bit count for legal steps, flags wraps and restarts,
// and counts wraps. Define COUNT_MONITOR_SYNC_EN to insert the cm_sync2 synchronizer on q.
module count_monitor
   import count_monitor_pkg::*;
#(
   parameter int WRAP_W = WRAP_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        q,
   input  logic              err_clr,
   output logic              wrap_pulse,
   output logic              restart_pulse,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              step_err,
   output logic [1:0]        state
);

   localparam logic [WRAP_W-1:0] CNT_SAT = {WRAP_W{1'b1}};
   localparam logic [WRAP_W-1:0] CNT_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

   logic [3:0]        w_q_s;
   step_t             w_step;
   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_prev;
   logic [3:0]        w_prev_nxt;
   logic              r_wrap_pulse;
   logic              w_wrap_pulse_nxt;
   logic              r_restart_pulse;
   logic              w_restart_pulse_nxt;
   logic [WRAP_W-1:0] r_wrap_count;
   logic [WRAP_W-1:0] w_wrap_count_nxt;
   logic              r_step_err;

`ifdef COUNT_MONITOR_SYNC_EN
   cm_sync2 #(.W(4)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (q),
      .q     (w_q_s)
   );
`else
   assign w_q_s = q;
`endif

   assign w_step = classify_step(r_prev, w_q_s);

   // State register; also holds every registered output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= SYNC;
         r_prev          <= 4'd0;
         r_wrap_pulse    <= 1'b0;
         r_restart_pulse <= 1'b0;
         r_wrap_count    <= {WRAP_W{1'b0}};
         r_step_err      <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_prev          <= w_prev_nxt;
         r_wrap_pulse    <= w_wrap_pulse_nxt;
         r_restart_pulse <= w_restart_pulse_nxt;
         r_wrap_count    <= w_wrap_count_nxt;
         r_step_err      <= (w_state_nxt == ERROR);
      end
   end

   // Next-state logic; the unused encoding falls back to SYNC.
   always_comb begin
      w_state_nxt = SYNC;
      case (r_state)
         SYNC: begin
            w_state_nxt = TRACK;
         end
         TRACK: begin
            if (w_step == STEP_BAD) begin
               w_state_nxt = ERROR;
            end else begin
               w_state_nxt = TRACK;
            end
         end
         ERROR: begin
            if (err_clr) begin
               w_state_nxt = SYNC;
            end else begin
               w_state_nxt = ERROR;
            end
         end
         default: begin
            w_state_nxt = SYNC;
         end
      endcase
   end

   // Next values of prev, the pulses and the saturating wrap counter.
   always_comb begin
      w_prev_nxt          = r_prev;
      w_wrap_pulse_nxt    = 1'b0;
      w_restart_pulse_nxt = 1'b0;
      w_wrap_count_nxt    = r_wrap_count;
      case (r_state)
         SYNC: begin
            w_prev_nxt = w_q_s;
         end
         TRACK: begin
            w_prev_nxt = w_q_s;
            if (w_step == STEP_WRAP) begin
               w_wrap_pulse_nxt = 1'b1;
               if (r_wrap_count != CNT_SAT) begin
                  w_wrap_count_nxt = r_wrap_count + CNT_ONE;
               end else begin
                  w_wrap_count_nxt = r_wrap_count;
               end
            end else if (w_step == STEP_RESTART) begin
               w_restart_pulse_nxt = 1'b1;
            end else begin
               w_restart_pulse_nxt = 1'b0;
            end
         end
         default: begin
            w_prev_nxt = r_prev;
         end
      endcase
   end

   assign wrap_pulse    = r_wrap_pulse;
   assign restart_pulse = r_restart_pulse;
   assign wrap_count    = r_wrap_count;
   assign step_err      = r_step_err;
   assign state         = r_state;

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: directed scenarios plus random
// stimulus against a behavioural model. Honours COUNT_MONITOR_SYNC_EN.
module tb_count_monitor;

`ifdef COUNT_MONITOR_SYNC_EN
   localparam int SYNC_DLY = 2;
`else
   localparam int SYNC_DLY = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] q = 4'd0;
   logic       err_clr = 1'b0;
   logic       wrap_pulse, restart_pulse, step_err;
   logic [7:0] wrap_count;
   logic [1:0] state;
   logic       wrap_pulse2, restart_pulse2, step_err2;
   logic [1:0] wrap_count2;
   logic [1:0] state2;

   count_monitor #(.WRAP_W(8)) dut (
      .clk(clk), .reset(reset), .q(q), .err_clr(err_clr),
      .wrap_pulse(wrap_pulse), .restart_pulse(restart_pulse),
      .wrap_count(wrap_count), .step_err(step_err), .state(state)
   );

   count_monitor #(.WRAP_W(2)) dut2 (
      .clk(clk), .reset(reset), .q(q), .err_clr(err_clr),
      .wrap_pulse(wrap_pulse2), .restart_pulse(restart_pulse2),
      .wrap_count(wrap_count2), .step_err(step_err2), .state(state2)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Behavioural model: 0=SYNC 1=TRACK 2=ERROR, q_s history for the synchronizer.
   int m_state = 0, m_prev = 0, h0 = 0, h1 = 0;
   int e_wrap = 0, e_restart = 0, e_cnt8 = 0, e_cnt2 = 0;
   logic [15:0] e_vec, a_vec;

   assign a_vec = {wrap_pulse, restart_pulse, wrap_count, step_err, state, wrap_pulse2, wrap_count2};

   task automatic tick(input logic [3:0] qv, input logic clr, input logic rst);
      int qs, d;
      @(negedge clk);
      q = qv; err_clr = clr; reset = rst;
      @(posedge clk);
      #1;
      e_wrap = 0; e_restart = 0;
      if (rst) begin
         m_state = 0; m_prev = 0; e_cnt8 = 0; e_cnt2 = 0; h0 = 0; h1 = 0;
      end else begin
         qs = (SYNC_DLY != 0) ? h0 : int'(qv);
         h0 = h1; h1 = int'(qv);
         if (m_state == 0) begin
            m_prev = qs; m_state = 1;
         end else if (m_state == 1) begin
            d = (qs - m_prev + 16) % 16;
            if (m_prev == 15 && qs == 0) begin
               e_wrap = 1;
               e_cnt8 = (e_cnt8 < 255) ? e_cnt8 + 1 : 255;
               e_cnt2 = (e_cnt2 < 3) ? e_cnt2 + 1 : 3;
            end else if (qs == 0 && m_prev >= 1 && m_prev <= 14) begin
               e_restart = 1;
            end else if (!(d == 0 || (d == 1 && m_prev != 15))) begin
               m_state = 2;
            end
            m_prev = qs;
         end else if (clr) begin
            m_state = 0;
         end
      end
      e_vec = {e_wrap[0], e_restart[0], e_cnt8[7:0], (m_state == 2), m_state[1:0], e_wrap[0], e_cnt2[1:0]};
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         tick(4'd7, 1'b1, 1'b1);
         checks++;
         if (a_vec !== e_vec) begin
            errors++; $display("FAIL reset cyc=%0d act=%h exp=%h", i, a_vec, e_vec);
         end
      end
      checks++;
      if ({wrap_count, state, step_err} !== 11'd0) begin
         errors++; $display("FAIL reset_zero act=%h exp=0", {wrap_count, state, step_err});
      end
   endtask

   task automatic test_wrap();
      int npulse = 0, at = -1;
      tick(4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick(4'(i % 16), 1'b0, 1'b0);
         checks++;
         if (a_vec !== e_vec) begin
            errors++; $display("FAIL wrap cyc=%0d act=%h exp=%h", i, a_vec, e_vec);
         end
         if (wrap_pulse) begin npulse++; at = i; end
      end
      checks++;
      if (npulse !== 1 || at !== 16 + SYNC_DLY) begin
         errors++; $display("FAIL wrap_timing pulses=%0d at=%0d exp 1 at %0d", npulse, at, 16 + SYNC_DLY);
      end
      checks++;
      if (wrap_count !== 8'd1 || step_err !== 1'b0) begin
         errors++; $display("FAIL wrap_count act=%0d err=%b exp 1 0", wrap_count, step_err);
      end
   endtask

   task automatic test_restart();
      int nr = 0, nw = 0;
      tick(4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 9 + SYNC_DLY; i++) begin
         tick((i < 8) ? 4'(i) : 4'd0, 1'b0, 1'b0);
         checks++;
         if (a_vec !== e_vec) begin
            errors++; $display("FAIL restart cyc=%0d act=%h exp=%h", i, a_vec, e_vec);
         end
         nr += int'(restart_pulse); nw += int'(wrap_pulse);
      end
      checks++;
      if (nr !== 1 || nw !== 0 || wrap_count !== 8'd0 || state !== 2'd1) begin
         errors++; $display("FAIL restart_summary restarts=%0d wraps=%0d cnt=%0d state=%0d exp 1 0 0 1", nr, nw, wrap_count, state);
      end
   endtask

   task automatic test_error();
      logic [3:0] seq [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd10, 4'd11, 4'd0, 4'd0, 4'd0};
      int np = 0;
      tick(4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick(seq[i], 1'b0, 1'b0);
         checks++;
         if (a_vec !== e_vec) begin
            errors++; $display("FAIL error cyc=%0d act=%h exp=%h", i, a_vec, e_vec);
         end
         np += int'(wrap_pulse) + int'(restart_pulse);
      end
      checks++;
      if (np !== 0 || state !== 2'd2 || step_err !== 1'b1) begin
         errors++; $display("FAIL error_hold pulses=%0d state=%0d err=%b exp 0 2 1", np, state, step_err);
      end
      tick(4'd0, 1'b1, 1'b0);
      checks++;
      if (state !== 2'd0 || step_err !== 1'b0) begin
         errors++; $display("FAIL error_clr state=%0d err=%b exp 0 0", state, step_err);
      end
      tick(4'd0, 1'b0, 1'b0);
      checks++;
      if (state !== 2'd1) begin
         errors++; $display("FAIL error_resync state=%0d exp 1", state);
      end
   endtask

   task automatic test_saturate();
      int sat_tab [5] = '{1, 2, 3, 3, 3};
      int k = 0;
      tick(4'd0, 1'b0, 1'b1);
      for (int i = 0; i <= 80 + SYNC_DLY; i++) begin
         tick(4'(i % 16), 1'b0, 1'b0);
         checks++;
         if (a_vec !== e_vec) begin
            errors++; $display("FAIL saturate cyc=%0d act=%h exp=%h", i, a_vec, e_vec);
         end
         if (wrap_pulse2) begin
            if (k < 5) begin
               checks++;
               if (int'(wrap_count2) !== sat_tab[k]) begin
                  errors++; $display("FAIL sat_count wrap=%0d act=%0d exp=%0d", k + 1, wrap_count2, sat_tab[k]);
               end
            end
            k++;
         end
      end
      checks++;
      if (k !== 5 || wrap_count !== 8'd5) begin
         errors++; $display("FAIL sat_pulses pulses=%0d cnt8=%0d exp 5 5", k, wrap_count);
      end
   endtask

   task automatic test_reset_priority();
      tick(4'd0, 1'b0, 1'b1);
      tick(4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3 + SYNC_DLY; i++) tick(4'd8, 1'b0, 1'b0);
      checks++;
      if (state !== 2'd2) begin
         errors++; $display("FAIL prio_enter_err state=%0d exp 2", state);
      end
      tick(4'd8, 1'b1, 1'b1);
      checks++;
      if (a_vec !== 16'd0 || a_vec !== e_vec) begin
         errors++; $display("FAIL prio_err_reset act=%h exp=%h", a_vec, e_vec);
      end
      for (int i = 0; i <= 32 + SYNC_DLY; i++) begin
         tick(4'(i % 16), 1'b0, (i == 32 + SYNC_DLY) ? 1'b1 : 1'b0);
         checks++;
         if (a_vec !== e_vec) begin
            errors++; $display("FAIL prio_wrap cyc=%0d act=%h exp=%h", i, a_vec, e_vec);
         end
         if (i == 31 + SYNC_DLY) begin
            checks++;
            if (wrap_count !== 8'd1) begin
               errors++; $display("FAIL prio_pre_count act=%0d exp=1", wrap_count);
            end
         end
      end
      checks++;
      if (a_vec !== 16'd0) begin
         errors++; $display("FAIL prio_wrap_reset act=%h exp=0", a_vec);
      end
   endtask

   task automatic test_random();
      logic [3:0] qv = 4'd0;
      int r;
      tick(4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 60) qv = qv + 4'd1;
         else if (r < 75) qv = qv;
         else if (r < 85) qv = 4'd0;
         else qv = 4'($urandom_range(0, 15));
         tick(qv, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
         checks++;
         if (a_vec !== e_vec) begin
            errors++; $display("FAIL random cyc=%0d q=%0d act=%h exp=%h", i, qv, a_vec, e_vec);
         end
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_restart();
      test_error();
      test_saturate();
      test_reset_priority();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter: WRAP_W, 8, width of the wrap-event counter (legal range 2..16).
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: q  input  4  count value from the upstream 4-bit counter; may change asynchronously to clk.
REQ-005 Port: err_clr  input  1  one-cycle request to leave ERROR.
REQ-006 Port: wrap_pulse  output  1  one-cycle pulse on each legal 15->0 step.
REQ-007 Port: restart_pulse  output  1  one-cycle pulse on each step to 0 from a value in 1..14.
REQ-008 Port: wrap_count  output  WRAP_W  number of wraps since reset, saturating.
REQ-009 Port: step_err  output  1  high while the FSM is in ERROR.
REQ-010 Port: state  output  2  current FSM state encoding.

Function
REQ-011 The checker operates on q_s, which is q through the optional synchronizer (REQ-024/025).
REQ-012 FSM states: SYNC=2'd0, TRACK=2'd1, ERROR=2'd2; 2'd3 is unreachable and recovers to SYNC on the next edge.
REQ-013 SYNC: on the next edge, load prev<=q_s, go to TRACK, assert no pulses.
REQ-014 TRACK: on each edge, compute delta=(q_s-prev) mod 16, then set prev<=q_s.
REQ-015 delta=0 (hold) and delta=1 with prev!=15 are legal and produce no pulse.
REQ-016 prev=15 and q_s=0 is a legal wrap: wrap_pulse=1 for one cycle and wrap_count increments.
REQ-017 q_s=0 with prev in 1..14 is a legal restart: restart_pulse=1 for one cycle; wrap_count is unchanged.
REQ-018 Any other delta is illegal: go to ERROR; no pulse; wrap_count is unchanged.
REQ-019 ERROR: prev is frozen, no pulses are produced, and step_err=1.
REQ-020 ERROR with err_clr=1 at an edge goes to SYNC; err_clr is ignored in SYNC and TRACK.
REQ-021 wrap_count saturates at 2^WRAP_W-1; a further wrap still pulses wrap_pulse but does not change the count.
REQ-022 All outputs are registered; the pulses are high for exactly one clk cycle.

Reset
REQ-023 reset=1 at an edge gives: state=SYNC, prev=0, wrap_pulse=0, restart_pulse=0, wrap_count=0, step_err=0, and synchronizer flops=0; reset takes priority over all other inputs, including mid-ERROR and mid-wrap.

Configuration
REQ-024 With COUNT_MONITOR_SYNC_EN defined, q_s is q through two clk flops; outputs reflect a q value at the third rising edge after q settles.
REQ-025 Without COUNT_MONITOR_SYNC_EN, q_s=q directly; outputs reflect q at the first rising edge after q settles; q must then be synchronous to clk.

Structure
REQ-026 The shared package count_monitor_pkg holds the state typedef (SYNC/TRACK/ERROR), the constant CNT_MAX=4'd15, and the default for WRAP_W.
REQ-027 The synchronizer is the sub-module cm_sync2 (4-bit, two-flop); it is instantiated only under COUNT_MONITOR_SYNC_EN.

Verification
REQ-028 q steps 0,1,...,15,0,1 once per clk after reset release -> one wrap_pulse at the 15->0 step, wrap_count=1, step_err=0.
REQ-029 q goes 5,6,7 then 0 (upstream reset) -> one restart_pulse, no wrap_pulse, wrap_count unchanged, state=TRACK.
REQ-030 q jumps 3->9 -> state=ERROR and step_err=1 at the latency edge; later steps produce no pulses; err_clr pulse -> SYNC, then TRACK on the next edge.
REQ-031 WRAP_W=2 with five wraps -> wrap_count is 1,2,3,3,3 and there are five wrap_pulses.
REQ-032 reset asserted for one cycle while in ERROR, and again on the same edge as a 15->0 step -> all outputs 0, state=SYNC, no wrap_pulse.
REQ-033 Run REQ-028 both with and without COUNT_MONITOR_SYNC_EN -> pulse timing differs by exactly 2 cycles and the counts are identical.
